// File: rtl/fnd_scan_controller.sv
// Multiplexed 7-segment (FND) driver: serial double-dabble binary-to-BCD conversion feeding a
// scanned display with decimal points, leading-zero blanking, overflow dashes and blinking.
module fnd_scan_controller #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned DATA_W      = 14,
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned SCAN_HZ     = 1000,
    parameter int unsigned BLINK_TICKS = 250
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_value,
    input  logic              i_load,
    output logic              o_busy,
    input  logic [DIGITS-1:0] i_dp_mask,
    input  logic              i_blank_lz,
    input  logic              i_blink_en,
    output logic              o_overflow,
    output logic [DIGITS-1:0] fnd_com,
    output logic [7:0]        fnd_data
);

    localparam int unsigned BCD_W    = 4 * (DIGITS + 1);
    localparam int unsigned TICK_DIV = CLK_HZ / SCAN_HZ;
    localparam int unsigned TCNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned BCNT_W   = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int unsigned CNT_W    = $clog2(DATA_W);

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                lost_q, lost_d;
    logic [DIGITS*4-1:0] disp_q, disp_d;
    logic                ovf_q, ovf_d;

    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < int'(DIGITS) + 1; i++) begin
            if (b[4*i +: 4] > 4'd4) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bcd_q     <= '0;
            bit_cnt_q <= '0;
            lost_q    <= 1'b0;
            disp_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bcd_q     <= bcd_d;
            bit_cnt_q <= bit_cnt_d;
            lost_q    <= lost_d;
            disp_q    <= disp_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bcd_d     = bcd_q;
        bit_cnt_d = bit_cnt_q;
        lost_d    = lost_q;
        disp_d    = disp_q;
        ovf_d     = ovf_q;
        bcd_adj   = add3(bcd_q);
        unique case (state_q)
            StIdle: begin
                if (i_load) begin
                    shift_d   = i_value;
                    bcd_d     = '0;
                    bit_cnt_d = '0;
                    lost_d    = 1'b0;
                    state_d   = StConv;
                end
            end
            StConv: begin
                bcd_d     = {bcd_adj[BCD_W-2:0], shift_q[DATA_W-1]};
                shift_d   = {shift_q[DATA_W-2:0], 1'b0};
                // A bit falling off the top of the BCD register means the value is far out of range
                lost_d    = lost_q | bcd_adj[BCD_W-1];
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == CNT_W'(DATA_W - 1)) state_d = StDone;
            end
            StDone: begin
                disp_d  = bcd_q[DIGITS*4-1:0];
                ovf_d   = lost_q | (bcd_q[BCD_W-1 -: 4] != 4'd0);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign o_busy     = (state_q != StIdle);
    assign o_overflow = ovf_q;

    logic [TCNT_W-1:0] tick_cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic [BCNT_W-1:0] blink_cnt_q;
    logic              blink_on_q;
    logic [DIGITS-1:0] com_q, com_next;
    logic [7:0]        data_q, data_next;
    logic              tick;
    logic [DIGITS-1:0] lz;
    logic              zero_above, cur_lz, cur_dp, blank;
    logic [3:0]        cur_digit;

    assign tick = (tick_cnt_q == TCNT_W'(TICK_DIV - 1));

    always_comb begin
        lz         = '0;
        zero_above = 1'b1;
        cur_digit  = '0;
        cur_lz     = 1'b0;
        cur_dp     = 1'b0;
        // lz[i]: digit i and every digit above it are zero
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            zero_above = zero_above & (disp_q[4*i +: 4] == 4'd0);
            lz[i]      = zero_above;
        end
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_digit = disp_q[4*i +: 4];
                cur_lz    = lz[i];
                cur_dp    = i_dp_mask[i];
            end
        end
        blank = i_blank_lz & ~ovf_q & (idx_q != '0) & cur_lz;
        if (blank)      data_next = 8'hFF;
        else if (ovf_q) data_next = {~cur_dp, 7'h3F};
        else            data_next = {~cur_dp, hex7(cur_digit)};
        if (i_blink_en && !blink_on_q) com_next = '1;
        else                           com_next = ~(DIGITS'(1) << idx_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q  <= '0;
            idx_q       <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            com_q       <= '1;
            data_q      <= 8'hFF;
        end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + TCNT_W'(1);
            if (tick) begin
                com_q  <= com_next;
                data_q <= data_next;
                idx_q  <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
                if (blink_cnt_q == BCNT_W'(BLINK_TICKS - 1)) begin
                    blink_cnt_q <= '0;
                    blink_on_q  <= ~blink_on_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + BCNT_W'(1);
                end
            end
        end
    end

    assign fnd_com  = com_q;
    assign fnd_data = data_q;

endmodule

// File: doc/fnd_scan_controller.md
FND_SCAN_CONTROLLER -- requirements
Module: fnd_scan_controller

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed digits, legal 1..8.
REQ-002 SHALL have parameter DATA_W, default 14, binary input width, legal 4..27.
REQ-003 SHALL have parameter CLK_HZ, default 100_000_000, clk frequency.
REQ-004 SHALL have parameter SCAN_HZ, default 1000, per-digit refresh tick rate.
REQ-005 SHALL have parameter BLINK_TICKS, default 250, scan ticks per blink half-period.
REQ-006 SHALL have port clk  input  1  system clock, rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port i_value  input  DATA_W  unsigned binary value to display.
REQ-009 SHALL have port i_load  input  1  single-cycle request to convert i_value.
REQ-010 SHALL have port o_busy  output  1  conversion in progress.
REQ-011 SHALL have port i_dp_mask  input  DIGITS  decimal point enable per digit, bit 0 = units.
REQ-012 SHALL have port i_blank_lz  input  1  leading-zero blanking enable.
REQ-013 SHALL have port i_blink_en  input  1  whole-display blink enable.
REQ-014 SHALL have port o_overflow  output  1  last converted value exceeded 10^DIGITS-1.
REQ-015 SHALL have port fnd_com  output  DIGITS  active-low one-hot digit enable.
REQ-016 SHALL have port fnd_data  output  8  active-low segments, bit 7 = dp.

Function
REQ-017 SHALL implement FSM IDLE -> CONV -> DONE -> IDLE for binary-to-BCD conversion.
REQ-018 SHALL, in IDLE with i_load=1, capture i_value and enter CONV next cycle; o_busy=1 from the cycle after i_load through DONE.
REQ-019 SHALL ignore i_load while o_busy=1; no queuing.
REQ-020 SHALL perform shift-add-3 (double dabble), one bit per cycle, DATA_W cycles in CONV, BCD width 4*(DIGITS+1) internally.
REQ-021 SHALL, in DONE, atomically update the display BCD register and o_overflow, then return to IDLE; total latency i_load to display update = DATA_W+2 cycles.
REQ-022 SHALL set o_overflow=1 when the converted value > 10^DIGITS-1; while set, every digit displays dash 8'hBF, dp still per mask.
REQ-023 SHALL generate a scan tick every CLK_HZ/SCAN_HZ clk cycles via a free-running counter wrapping at CLK_HZ/SCAN_HZ-1.
REQ-024 SHALL advance digit index on each tick, wrapping DIGITS-1 -> 0.
REQ-025 SHALL register fnd_com and fnd_data one cycle after each tick; both change in the same cycle (no ghosting between digits).
REQ-026 SHALL encode hex 0..F with codes C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E; bit 7 = ~i_dp_mask[index].
REQ-027 SHALL, when i_blank_lz=1, output 8'hFF (dp included) for a digit whose value and all higher digits are zero; digit 0 never blanked; overflow disables blanking.
REQ-028 SHALL toggle a blink phase every BLINK_TICKS ticks; when i_blink_en=1 and phase=off, fnd_com = all ones; phase counter runs regardless of i_blink_en.
REQ-029 SHALL keep scanning the previous display value during CONV (no flicker to partial results).

Reset
REQ-030 SHALL, on rst, asynchronously clear: FSM=IDLE, o_busy=0, o_overflow=0, display BCD=0, tick counter=0, digit index=0, blink phase=on.
REQ-031 SHALL hold fnd_com = all ones and fnd_data = 8'hFF during reset and until the first scan tick.
REQ-032 SHALL abort an in-progress conversion on rst; no partial result reaches the display.

Verification (CLK_HZ=1000, SCAN_HZ=250, BLINK_TICKS=4, DIGITS=4, DATA_W=14)
REQ-033 SHALL test: load 1234 -> o_busy high 15 cycles, then scan shows digits 4,3,2,1 with fnd_com 1110,1101,1011,0111, fnd_data 99,B0,A4,F9.
REQ-034 SHALL test: load 9999 then 10000 -> first o_overflow=0; second o_overflow=1, all digits 8'hBF.
REQ-035 SHALL test: load 7, i_blank_lz=1, i_dp_mask=4'b0010 -> digits 1..3 = FF, digit 0 = F8; with i_blank_lz=0 digit 1 = 40.
REQ-036 SHALL test: i_load pulsed again mid-CONV with different value -> ignored, first value displayed.
REQ-037 SHALL test: i_blink_en=1 -> fnd_com all ones for 4 ticks, active for 4 ticks, repeating.
REQ-038 SHALL test: rst asserted mid-CONV -> o_busy=0 immediately, outputs FF/all ones, display value 0 afterwards.
